// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code-set-2 receiver with game-key decoder.
// Filters the PS/2 clock, frames bytes, and keeps a held-key vector for up/left/right/down/jump.
module ps2_key_decoder #(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [4:0] keydown,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);

    localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          filt_clk;
    logic [FW-1:0] filt_cnt;
    logic          fall;

    state_t        state, state_n;
    logic [2:0]    bitcnt, bitcnt_n;
    logic [7:0]    shreg, shreg_n;
    logic          par, par_n;
    logic [TW-1:0] tocnt, tocnt_n;
    logic          valid_n, err_n;

    logic          ext, brk;
    logic [4:0]    map_mask;

    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Counter runs only while the synced level disagrees with the filtered one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_s2 == filt_clk) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FILT_LAST) begin
            filt_clk <= clk_s2;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + FW'(1);
        end
    end

    assign fall = filt_clk && !clk_s2 && (filt_cnt == FILT_LAST);

    always_comb begin
        state_n  = state;
        bitcnt_n = bitcnt;
        shreg_n  = shreg;
        par_n    = par;
        tocnt_n  = '0;
        valid_n  = 1'b0;
        err_n    = 1'b0;

        if (state != IDLE && !fall) begin
            tocnt_n = tocnt + TW'(1);
        end

        case (state)
            IDLE: begin
                if (fall && !dat_s2) begin
                    state_n  = DATA;
                    bitcnt_n = '0;
                end
            end
            DATA: begin
                if (fall) begin
                    shreg_n  = {dat_s2, shreg[7:1]};
                    bitcnt_n = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) begin
                        state_n = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    par_n   = dat_s2;
                    state_n = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_n = IDLE;
                    if (dat_s2 && ((^shreg) ^ par)) begin
                        valid_n = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (state != IDLE && !fall && tocnt == TO_LAST) begin
            state_n = IDLE;
            err_n   = 1'b1;
            tocnt_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            bitcnt     <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            tocnt      <= '0;
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
            scan_code  <= '0;
        end else begin
            state      <= state_n;
            bitcnt     <= bitcnt_n;
            shreg      <= shreg_n;
            par        <= par_n;
            tocnt      <= tocnt_n;
            scan_valid <= valid_n;
            frame_err  <= err_n;
            if (valid_n) begin
                scan_code <= shreg;
            end
        end
    end

    // Extended arrows and WASD alias onto the same bits; keypad codes stay unmapped.
    always_comb begin
        map_mask = '0;
        if (ext) begin
            case (scan_code)
                8'h75:   map_mask = 5'b00001;
                8'h6B:   map_mask = 5'b00010;
                8'h74:   map_mask = 5'b00100;
                8'h72:   map_mask = 5'b01000;
                default: map_mask = '0;
            endcase
        end else begin
            case (scan_code)
                8'h1D:   map_mask = 5'b00001;
                8'h1C:   map_mask = 5'b00010;
                8'h23:   map_mask = 5'b00100;
                8'h1B:   map_mask = 5'b01000;
                8'h29:   map_mask = 5'b10000;
                default: map_mask = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            keydown <= '0;
            ext     <= 1'b0;
            brk     <= 1'b0;
        end else if (scan_valid) begin
            if (scan_code == 8'hE0) begin
                ext <= 1'b1;
            end else if (scan_code == 8'hF0) begin
                brk <= 1'b1;
            end else begin
                keydown <= brk ? (keydown & ~map_mask) : (keydown | map_mask);
                ext     <= 1'b0;
                brk     <= 1'b0;
            end
        end
    end

endmodule
